// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM register controller.
// Address constants describe the default eight-channel register map.
package pwm_ctrl_pkg;

   localparam int NCH_DEFAULT = 8;
   localparam int DW_DEFAULT  = 8;

   localparam int         NREG        = NCH_DEFAULT + 2;
   localparam logic [7:0] ADDR_CTRL   = 8'(NCH_DEFAULT);
   localparam logic [7:0] ADDR_COMMIT = 8'(NCH_DEFAULT + 1);

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_AUTO_BIT   = 1;
   localparam int CTRL_ERRCLR_BIT = 7;
   localparam int COMMIT_REQ_BIT  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PTR  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   // The last mapped address wraps to 0; unmapped pointers just count on with 8-bit wrap.
   function automatic logic [7:0] ptr_advance(input logic [7:0] p, input int nreg);
      return (p == 8'(nreg - 1)) ? 8'd0 : p + 8'd1;
   endfunction

endpackage

// File: rtl/pwm_reg_ctrl_if.sv
// Byte-level strobe interface between the I2C slave front end and the register controller.
interface pwm_reg_ctrl_if;

   logic       i2c_start;
   logic       i2c_stop;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       rd_valid;

   modport master (
      output i2c_start, i2c_stop, rx_valid, rx_data, rd_req,
      input  rd_data, rd_valid
   );

   modport slave (
      input  i2c_start, i2c_stop, rx_valid, rx_data, rd_req,
      output rd_data, rd_valid
   );

endinterface

// File: rtl/pwm_shadow_bank.sv
// Shadow and active duty registers with a commit flag; the active set is copied
// from the shadow set only at a PWM period boundary.
module pwm_shadow_bank #(
   parameter int NCH  = 8,
   parameter int DW   = 8,
   parameter int IDXW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDXW-1:0]   wr_idx,
   input  logic [DW-1:0]     wr_data,
   input  logic              auto_commit,
   input  logic              commit_req,
   input  logic              period_end,
   output logic [NCH*DW-1:0] shadow_flat,
   output logic [NCH*DW-1:0] duty,
   output logic              pending
);

   logic pending_reg;
   logic pending_next;
   logic set_evt;
   logic copy_en;

   assign set_evt = commit_req | (wr_en & auto_commit);
   assign copy_en = period_end & pending_reg;
   // A set event on the copy edge keeps the flag up for the following boundary.
   assign pending_next = set_evt | (pending_reg & ~period_end);
   assign pending = pending_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= 1'b0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [DW-1:0] shadow_reg;
         logic [DW-1:0] active_reg;
         logic [DW-1:0] duty_reg;

         // Copy uses the pre-edge shadow value, so a same-cycle write waits for the next commit.
         always_ff @(posedge clk) begin
            if (rst) begin
               shadow_reg <= '0;
               active_reg <= '0;
               duty_reg   <= '0;
            end else begin
               if (wr_en && (wr_idx == IDXW'(gi))) begin
                  shadow_reg <= wr_data;
               end
               if (copy_en) begin
                  active_reg <= shadow_reg;
               end
               duty_reg <= active_reg;
            end
         end

         assign shadow_flat[gi*DW +: DW] = shadow_reg;
         assign duty[gi*DW +: DW]        = duty_reg;
      end
   endgenerate

endmodule

// File: rtl/pwm_reg_ctrl.sv
// I2C byte-stream register controller: pointer/data FSM, address decode and
// read-back mux in front of the shadow/active duty bank.
module pwm_reg_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int NCH             = NCH_DEFAULT,
   parameter int DW              = DW_DEFAULT,
   parameter bit AUTO_COMMIT_RST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   pwm_reg_ctrl_if.slave     bus,
   input  logic              period_end,
   output logic [NCH*DW-1:0] duty,
   output logic              enable,
   output logic              commit_pending,
   output logic              err
);

   localparam int         IDXW          = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int         NREG_L        = NCH + 2;
   localparam logic [7:0] ADDR_CTRL_L   = 8'(NCH);
   localparam logic [7:0] ADDR_COMMIT_L = 8'(NCH + 1);

   state_e     state_reg, state_next;
   logic [7:0] ptr_reg, ptr_next;
   logic       enable_reg, enable_next;
   logic       auto_reg, auto_next;
   logic       err_reg, err_next;
   logic [7:0] rd_data_reg, rd_data_next;
   logic       rd_valid_reg, rd_valid_next;

   logic [7:0]        cur_ptr;
   logic              wr_duty;
   logic              commit_req;
   logic [NCH*DW-1:0] shadow_flat;
   logic [DW-1:0]     shadow_arr [NCH];

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_unpack
         assign shadow_arr[gi] = shadow_flat[gi*DW +: DW];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= 8'd0;
         enable_reg   <= 1'b0;
         auto_reg     <= AUTO_COMMIT_RST;
         err_reg      <= 1'b0;
         rd_data_reg  <= 8'd0;
         rd_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         enable_reg   <= enable_next;
         auto_reg     <= auto_next;
         err_reg      <= err_next;
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      enable_next   = enable_reg;
      auto_next     = auto_reg;
      err_next      = err_reg;
      rd_data_next  = rd_data_reg;
      rd_valid_next = 1'b0;
      wr_duty       = 1'b0;
      commit_req    = 1'b0;
      cur_ptr       = ptr_reg;

      if (bus.i2c_start) begin
         state_next = ST_PTR;
      end else begin
         case (state_reg)
            ST_PTR: begin
               if (bus.rx_valid) begin
                  cur_ptr    = bus.rx_data;
                  state_next = ST_DATA;
               end
            end
            ST_DATA: begin
               if (bus.rx_valid) begin
                  if (ptr_reg < ADDR_CTRL_L) begin
                     wr_duty = 1'b1;
                  end else if (ptr_reg == ADDR_CTRL_L) begin
                     enable_next = bus.rx_data[CTRL_ENABLE_BIT];
                     auto_next   = bus.rx_data[CTRL_AUTO_BIT];
                     if (bus.rx_data[CTRL_ERRCLR_BIT]) begin
                        err_next = 1'b0;
                     end
                  end else if (ptr_reg == ADDR_COMMIT_L) begin
                     commit_req = bus.rx_data[COMMIT_REQ_BIT];
                  end else begin
                     err_next = 1'b1;
                  end
                  cur_ptr = ptr_advance(ptr_reg, NREG_L);
               end
            end
            default: ;
         endcase
         if (bus.i2c_stop) begin
            state_next = ST_IDLE;
         end
      end

      // Reads use the pointer after any same-cycle write has advanced it.
      ptr_next = cur_ptr;
      if (bus.rd_req) begin
         rd_valid_next = 1'b1;
         if (cur_ptr < ADDR_CTRL_L) begin
            rd_data_next = 8'(shadow_arr[cur_ptr[IDXW-1:0]]);
         end else if (cur_ptr == ADDR_CTRL_L) begin
            rd_data_next                  = 8'd0;
            rd_data_next[CTRL_ENABLE_BIT] = enable_reg;
            rd_data_next[CTRL_AUTO_BIT]   = auto_reg;
         end else if (cur_ptr == ADDR_COMMIT_L) begin
            rd_data_next = {7'd0, commit_pending};
         end else begin
            rd_data_next = 8'hFF;
            err_next     = 1'b1;
         end
         ptr_next = ptr_advance(cur_ptr, NREG_L);
      end
   end

   pwm_shadow_bank #(
      .NCH  (NCH),
      .DW   (DW),
      .IDXW (IDXW)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_duty),
      .wr_idx      (ptr_reg[IDXW-1:0]),
      .wr_data     (bus.rx_data[DW-1:0]),
      .auto_commit (auto_reg),
      .commit_req  (commit_req),
      .period_end  (period_end),
      .shadow_flat (shadow_flat),
      .duty        (duty),
      .pending     (commit_pending)
   );

   assign bus.rd_data  = rd_data_reg;
   assign bus.rd_valid = rd_valid_reg;
   assign enable       = enable_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Directed bench for pwm_reg_ctrl: write/commit flow, auto-commit, pointer wrap,
// unmapped access, read-back and simultaneous-event corner cases.
module tb_pwm_reg_ctrl;

   logic        clk;
   logic        rst;
   logic        period_end;
   logic [63:0] duty;
   logic        enable;
   logic        commit_pending;
   logic        err;

   int checks;
   int errors;

   pwm_reg_ctrl_if bus ();

   pwm_reg_ctrl #(
      .NCH             (8),
      .DW              (8),
      .AUTO_COMMIT_RST (1'b0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .period_end     (period_end),
      .duty           (duty),
      .enable         (enable),
      .commit_pending (commit_pending),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_start();
      bus.i2c_start = 1'b1;
      tick();
      bus.i2c_start = 1'b0;
   endtask

   task automatic send_stop();
      bus.i2c_stop = 1'b1;
      tick();
      bus.i2c_stop = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_period();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
   endtask

   task automatic send_read();
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
   endtask

   task automatic set_ptr(input logic [7:0] p);
      send_start();
      send_byte(p);
      send_stop();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks++; if (duty !== 64'h0) begin errors++; $display("FAIL reset_duty: got %h want %h", duty, 64'h0); end
      checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", enable); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
      $display("test_reset done");
   endtask

   task automatic test_commit();
      send_start();
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h30);
      send_stop();
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL commit_no_auto_pending: got %b want 0", commit_pending); end
      send_start();
      send_byte(8'h09);
      send_byte(8'h01);
      send_stop();
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL commit_req_pending: got %b want 1", commit_pending); end
      checks++; if (duty !== 64'h0) begin errors++; $display("FAIL commit_before_period: got %h want %h", duty, 64'h0); end
      send_period();
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL commit_pending_clear: got %b want 0", commit_pending); end
      checks++; if (duty !== 64'h0) begin errors++; $display("FAIL commit_duty_latency: got %h want %h", duty, 64'h0); end
      tick();
      checks++; if (duty !== 64'h0000_0000_0030_2010) begin errors++; $display("FAIL commit_duty: got %h want %h", duty, 64'h0000_0000_0030_2010); end
      $display("test_commit done");
   endtask

   task automatic test_auto_commit();
      send_start();
      send_byte(8'h03);
      send_byte(8'h55);
      send_stop();
      repeat (3) send_period();
      tick();
      checks++; if (duty[31:24] !== 8'h00) begin errors++; $display("FAIL noauto_ch3: got %h want 00", duty[31:24]); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL noauto_pending: got %b want 0", commit_pending); end
      send_start();
      send_byte(8'h08);
      send_byte(8'h03);
      send_stop();
      checks++; if (enable !== 1'b1) begin errors++; $display("FAIL ctrl_enable: got %b want 1", enable); end
      send_start();
      send_byte(8'h03);
      send_byte(8'h66);
      send_stop();
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL auto_pending: got %b want 1", commit_pending); end
      send_period();
      tick();
      checks++; if (duty[31:24] !== 8'h66) begin errors++; $display("FAIL auto_ch3: got %h want 66", duty[31:24]); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL auto_pending_clear: got %b want 0", commit_pending); end
      $display("test_auto_commit done");
   endtask

   task automatic test_wrap();
      send_start();
      send_byte(8'h09);
      send_byte(8'h01);
      send_byte(8'hAA);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
      send_stop();
      send_period();
      tick();
      checks++; if (duty[7:0] !== 8'hAA) begin errors++; $display("FAIL wrap_ch0: got %h want AA", duty[7:0]); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL wrap_pending: got %b want 0", commit_pending); end
      $display("test_wrap done");
   endtask

   task automatic test_unmapped();
      send_start();
      send_byte(8'h20);
      send_byte(8'h12);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b want 1", err); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL unmapped_pending: got %b want 0", commit_pending); end
      checks++; if (duty !== 64'h0000_0000_6630_20AA) begin errors++; $display("FAIL unmapped_duty: got %h want %h", duty, 64'h0000_0000_6630_20AA); end
      send_stop();
      send_read();
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL unmapped_rd_valid: got %b want 1", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'hFF) begin errors++; $display("FAIL unmapped_rd_data: got %h want FF", bus.rd_data); end
      tick();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL unmapped_rd_valid_drop: got %b want 0", bus.rd_valid); end
      send_start();
      send_byte(8'h08);
      send_byte(8'h83);
      send_stop();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL errclr: got %b want 0", err); end
      checks++; if (enable !== 1'b1) begin errors++; $display("FAIL errclr_enable: got %b want 1", enable); end
      set_ptr(8'h08);
      send_read();
      checks++; if (bus.rd_data !== 8'h03) begin errors++; $display("FAIL ctrl_readback: got %h want 03", bus.rd_data); end
      $display("test_unmapped done");
   endtask

   task automatic test_back_to_back_read();
      set_ptr(8'h02);
      bus.rd_req = 1'b1;
      tick();
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL read1_valid: got %b want 1", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'h30) begin errors++; $display("FAIL read1_data: got %h want 30", bus.rd_data); end
      tick();
      bus.rd_req = 1'b0;
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL read2_valid: got %b want 1", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'h66) begin errors++; $display("FAIL read2_data: got %h want 66", bus.rd_data); end
      tick();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop: got %b want 0", bus.rd_valid); end
      $display("test_back_to_back_read done");
   endtask

   task automatic test_start_with_rx();
      send_start();
      send_byte(8'h00);
      bus.i2c_start = 1'b1;
      bus.rx_valid  = 1'b1;
      bus.rx_data   = 8'h77;
      tick();
      bus.i2c_start = 1'b0;
      bus.rx_valid  = 1'b0;
      send_byte(8'h05);
      send_byte(8'h44);
      send_stop();
      set_ptr(8'h00);
      send_read();
      checks++; if (bus.rd_data !== 8'hAA) begin errors++; $display("FAIL start_rx_dropped: got %h want AA", bus.rd_data); end
      set_ptr(8'h05);
      send_read();
      checks++; if (bus.rd_data !== 8'h44) begin errors++; $display("FAIL start_rx_ptr_state: got %h want 44", bus.rd_data); end
      $display("test_start_with_rx done");
   endtask

   task automatic test_commit_coincide();
      send_start();
      send_byte(8'h06);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h99;
      period_end   = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      period_end   = 1'b0;
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL coincide_pending: got %b want 1", commit_pending); end
      tick();
      checks++; if (duty[47:40] !== 8'h44) begin errors++; $display("FAIL coincide_ch5: got %h want 44", duty[47:40]); end
      checks++; if (duty[55:48] !== 8'h00) begin errors++; $display("FAIL coincide_ch6: got %h want 00", duty[55:48]); end
      send_stop();
      send_period();
      tick();
      checks++; if (duty[55:48] !== 8'h99) begin errors++; $display("FAIL coincide_ch6_next: got %h want 99", duty[55:48]); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL coincide_pending_clear: got %b want 0", commit_pending); end
      $display("test_commit_coincide done");
   endtask

   task automatic test_reset_mid();
      send_start();
      send_byte(8'h00);
      send_byte(8'h11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (duty !== 64'h0) begin errors++; $display("FAIL midrst_duty: got %h want %h", duty, 64'h0); end
      checks++; if (enable !== 1'b0) begin errors++; $display("FAIL midrst_enable: got %b want 0", enable); end
      checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL midrst_pending: got %b want 0", commit_pending); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data: got %h want 00", bus.rd_data); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %b want 0", bus.rd_valid); end
      send_byte(8'h22);
      send_read();
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL idle_rd_valid: got %b want 1", bus.rd_valid); end
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL idle_rx_ignored: got %h want 00", bus.rd_data); end
      $display("test_reset_mid done");
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      period_end    = 1'b0;
      bus.i2c_start = 1'b0;
      bus.i2c_stop  = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.rd_req    = 1'b0;
      test_reset();
      test_commit();
      test_auto_commit();
      test_wrap();
      test_unmapped();
      test_back_to_back_read();
      test_start_with_rx();
      test_commit_coincide();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
